// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, addresses the synchronous-read
// instruction memory and fills the IF/ID register that feeds decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 131072,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_instr_o,
  output logic        id_valid_o,
  output logic        id_fault_o
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_BYTES);

  logic [31:0] pc_q;
  logic [31:0] pc_next;
  logic        started_q;
  logic        started_d;
  logic        fault_c;
  logic [31:0] id_instr_d;
  logic        id_fault_d;
  logic        id_valid_d;

  // State register: PC and the boot flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= RESET_PC;
      started_q <= 1'b0;
    end else begin
      pc_q      <= pc_next;
      started_q <= started_d;
    end
  end

  // Next-state: redirect beats the boot hold, which beats stall.
  always_comb begin
    started_d = 1'b1;
    pc_next   = pc_q + 32'd4;
    if (redirect_i) begin
      pc_next = redirect_pc_i;
    end else if (!started_q || stall_i) begin
      pc_next = pc_q;
    end
  end

  // Outputs: memory address for the next PC and the IF/ID write data.
  // An out-of-range address is clamped to 0 so the memory is never overrun.
  always_comb begin
    imem_addr_o = {pc_next[31:2], 2'b00};
    if (pc_next >= IMEM_LIMIT) begin
      imem_addr_o = 32'd0;
    end
    fault_c    = (pc_q[1:0] != 2'b00) || (pc_q >= IMEM_LIMIT);
    id_instr_d = fault_c ? NOP_INSTR : imem_data_i;
    id_fault_d = fault_c & started_q;
    id_valid_d = started_q & ~redirect_i;
  end

  // IF/ID register. stall_i is downstream back-pressure: while it is high the
  // entry is held and the PC does not advance; flush_i overrides a stall.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_pc_o    <= 32'd0;
      id_instr_o <= NOP_INSTR;
      id_valid_o <= 1'b0;
      id_fault_o <= 1'b0;
    end else if (flush_i) begin
      id_valid_o <= 1'b0;
      id_fault_o <= 1'b0;
    end else if (!stall_i) begin
      id_pc_o    <= pc_q;
      id_instr_o <= id_instr_d;
      id_valid_o <= id_valid_d;
      id_fault_o <= id_fault_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed boot/stall/redirect/fault/reset steps, then
// random traffic, all checked against a behavioural model of the fetch rules.
module tb_fetch_stage;

  localparam int unsigned IMEM_BYTES = 131072;
  localparam int unsigned IMEM_WORDS = IMEM_BYTES / 4;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        stall_i;
  logic        flush_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_data_i;
  logic [31:0] id_pc_o;
  logic [31:0] id_instr_o;
  logic        id_valid_o;
  logic        id_fault_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:IMEM_WORDS-1];

  // Behavioural model state
  logic [31:0] m_pc;
  logic        m_booted;
  logic [31:0] m_id_pc;
  logic [31:0] m_id_instr;
  logic        m_id_valid;
  logic        m_id_fault;
  logic        m_id_known;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .IMEM_BYTES(IMEM_BYTES),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_addr_o  (imem_addr_o),
    .imem_data_i  (imem_data_i),
    .id_pc_o      (id_pc_o),
    .id_instr_o   (id_instr_o),
    .id_valid_o   (id_valid_o),
    .id_fault_o   (id_fault_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Synchronous-read instruction memory, one cycle of latency.
  always @(posedge clk_i) imem_data_i <= mem[imem_addr_o[16:2]];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic is_fault(input logic [31:0] pc);
    return ((pc % 4) != 0) || (pc >= IMEM_BYTES);
  endfunction

  function automatic logic [31:0] model_next(input logic st, input logic rd, input logic [31:0] rpc);
    if (rd) return rpc;
    if (!m_booted || st) return m_pc;
    return m_pc + 32'd4;
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] pc);
    if (pc >= IMEM_BYTES) return 32'd0;
    return pc - (pc % 4);
  endfunction

  task automatic model_reset();
    m_pc       = RESET_PC;
    m_booted   = 1'b0;
    m_id_pc    = 32'd0;
    m_id_instr = NOP_INSTR;
    m_id_valid = 1'b0;
    m_id_fault = 1'b0;
    m_id_known = 1'b1;
  endtask

  task automatic check_id(input string tag);
    check({tag, ".valid"}, {31'd0, id_valid_o}, {31'd0, m_id_valid});
    check({tag, ".fault"}, {31'd0, id_fault_o}, {31'd0, m_id_fault});
    if (m_id_known) begin
      check({tag, ".pc"}, id_pc_o, m_id_pc);
      check({tag, ".instr"}, id_instr_o, m_id_instr);
    end
  endtask

  // One clock cycle: drive at the falling edge, check the address before the
  // rising edge and the IF/ID contents just after it.
  task automatic cycle(input string tag, input logic st, input logic fl,
                       input logic rd, input logic [31:0] rpc);
    logic [31:0] nxt;
    logic [31:0] word;
    stall_i       = st;
    flush_i       = fl;
    redirect_i    = rd;
    redirect_pc_i = rpc;
    #1;
    nxt = model_next(st, rd, rpc);
    check({tag, ".addr"}, imem_addr_o, model_addr(nxt));
    @(posedge clk_i);
    word = is_fault(m_pc) ? NOP_INSTR : mem[m_pc / 4];
    if (fl) begin
      m_id_valid = 1'b0;
      m_id_fault = 1'b0;
    end else if (!st) begin
      m_id_pc    = m_pc;
      m_id_instr = word;
      m_id_fault = is_fault(m_pc) && m_booted;
      m_id_valid = m_booted && !rd;
      m_id_known = m_booted;
    end
    m_pc     = nxt;
    m_booted = 1'b1;
    #1;
    check_id(tag);
    @(negedge clk_i);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pc"}, id_pc_o, 32'd0);
    check({tag, ".instr"}, id_instr_o, NOP_INSTR);
    check({tag, ".valid"}, {31'd0, id_valid_o}, 32'd0);
    check({tag, ".fault"}, {31'd0, id_fault_o}, 32'd0);
    check({tag, ".addr"}, imem_addr_o, model_addr(RESET_PC));
  endtask

  function automatic logic [31:0] rand_target();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 6) return 32'($urandom_range(0, IMEM_WORDS - 1)) * 32'd4;
    if (sel == 6) return IMEM_BYTES - 32'd8;
    if (sel == 7) return 32'($urandom_range(0, 4095)) | 32'($urandom_range(1, 3));
    if (sel == 8) return 32'hFFFF_FFF8;
    return 32'(IMEM_BYTES) + 32'($urandom_range(0, 255)) * 32'd4;
  endfunction

  initial begin
    for (int i = 0; i < int'(IMEM_WORDS); i++) mem[i] = $urandom;
    rst_ni        = 1'b0;
    stall_i       = 1'b0;
    flush_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    repeat (3) @(negedge clk_i);
    check_reset_values("reset");

    // Boot: one idle cycle, then 0/A, 4/B
    rst_ni = 1'b1;
    model_reset();
    idle("boot", 3);

    // Stall for three cycles, then resume with no gap or duplicate
    for (int i = 0; i < 3; i++) cycle("stall", 1'b1, 1'b0, 1'b0, 32'd0);
    idle("resume", 2);

    // Redirect: one bubble, then the target
    cycle("redir", 1'b0, 1'b0, 1'b1, 32'h0000_0040);
    idle("redir_tgt", 2);

    // Redirect under stall, then flush, then the target arrives
    cycle("redir_stall", 1'b1, 1'b0, 1'b1, 32'h0000_0080);
    cycle("flush", 1'b0, 1'b1, 1'b0, 32'd0);
    idle("after_flush", 2);
    cycle("flush_stall", 1'b1, 1'b1, 1'b0, 32'd0);
    idle("after_fs", 1);

    // Faults: misaligned, out of range, and the wrap past 0xFFFF_FFFC
    cycle("mis", 1'b0, 1'b0, 1'b1, 32'h0000_0042);
    idle("mis_run", 3);
    cycle("oor", 1'b0, 1'b0, 1'b1, 32'h0002_0000);
    idle("oor_run", 2);
    cycle("edge", 1'b0, 1'b0, 1'b1, IMEM_BYTES - 32'd4);
    idle("edge_run", 3);
    cycle("wrap", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    idle("wrap_run", 3);

    // Asynchronous reset between edges, then a repeated boot
    #2;
    rst_ni = 1'b0;
    #1;
    check_reset_values("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    model_reset();
    cycle("boot_redir", 1'b0, 1'b0, 1'b1, 32'h0000_0100);
    idle("reboot", 3);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic st, fl, rd;
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 7) == 0);
      rd = ($urandom_range(0, 5) == 0);
      cycle("rand", st, fl, rd, rand_target());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
